w0rm_stream_arbiter: RTL and testbench

Round-robin arbiter that shares one valid/ready/data stream channel between NUM_REQ requesters. Arbitration is packet-based: the grant locks on a requester until a beat with input_last is accepted. The output is a single registered stage, for example feeding a bus synchroniser or memory port. It sits between the core's request sources (fetch, load/store, DMA) and the shared downstream channel.

---
 rtl/w0rm_stream_pkg.sv | 22 ++
 rtl/w0rm_rr_picker.sv | 34 +++
 rtl/w0rm_stream_arbiter.sv | 121 ++++++++++++
 tb/tb_w0rm_stream_arbiter.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/w0rm_stream_pkg.sv
// rtl/w0rm_stream_pkg.sv - shared FSM encoding and sizing helper for stream arbiters
package w0rm_stream_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  // Number of bits needed to index 'value' distinct items (0 for value <= 1).
  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v = value - 1;
    while (v > 0) begin
      result = result + 1;
      v = v >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/w0rm_rr_picker.sv
// rtl/w0rm_rr_picker.sv - combinational round-robin picker: first request at or after ptr, with wrap
module w0rm_rr_picker #(
  parameter int NUM_REQ   = 4,
  parameter int IDX_WIDTH = 2
) (
  input  logic [NUM_REQ-1:0]   req,
  input  logic [IDX_WIDTH-1:0] ptr,
  output logic                 found,
  output logic [IDX_WIDTH-1:0] idx
);

  logic [NUM_REQ-1:0] rotated;
  logic [IDX_WIDTH:0] first_off;
  logic [IDX_WIDTH:0] sum;

  // Rotate so bit k is requester (ptr + k) mod NUM_REQ; lowest set bit is the winner.
  always_comb begin
    rotated   = NUM_REQ'({req, req} >> ptr);
    found     = 1'b0;
    first_off = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (rotated[k]) begin
        found     = 1'b1;
        first_off = (IDX_WIDTH + 1)'(k);
      end
    end
    sum = {1'b0, ptr} + first_off;
    if (sum >= (IDX_WIDTH + 1)'(NUM_REQ)) begin
      sum = sum - (IDX_WIDTH + 1)'(NUM_REQ);
    end
    idx = sum[IDX_WIDTH-1:0];
  end

endmodule

// File: rtl/w0rm_stream_arbiter.sv
// rtl/w0rm_stream_arbiter.sv - packet-locked round-robin arbiter onto one registered stream stage
module w0rm_stream_arbiter
  import w0rm_stream_pkg::*;
#(
  parameter  int NUM_REQ    = 4,
  parameter  int DATA_WIDTH = 32,
  localparam int SRC_WIDTH  = (clog2(NUM_REQ) > 1) ? clog2(NUM_REQ) : 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            input_valid,
  output logic [NUM_REQ-1:0]            input_ready,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] input_data,
  input  logic [NUM_REQ-1:0]            input_last,
  output logic                          output_valid,
  input  logic                          output_ready,
  output logic [DATA_WIDTH-1:0]         output_data,
  output logic                          output_last,
  output logic [SRC_WIDTH-1:0]          output_src,
  output logic                          busy
);

  state_t                state, state_next;
  logic [SRC_WIDTH-1:0]  grant, grant_next;
  logic [SRC_WIDTH-1:0]  rr_ptr, rr_ptr_next;
  logic                  stage_free;
  logic                  accept;
  logic                  pick_found;
  logic [SRC_WIDTH-1:0]  pick_idx;
  logic                  sel_valid;
  logic                  sel_last;
  logic [DATA_WIDTH-1:0] sel_data;

  w0rm_rr_picker #(
    .NUM_REQ   (NUM_REQ),
    .IDX_WIDTH (SRC_WIDTH)
  ) u_picker (
    .req   (input_valid),
    .ptr   (rr_ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // Output stage can take a beat when empty or draining this cycle.
  assign stage_free = !output_valid || output_ready;
  assign accept     = (state == ST_GRANT) && sel_valid && stage_free;
  assign busy       = (state == ST_GRANT);

  // Route the granted requester's beat to the output stage.
  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant == SRC_WIDTH'(i)) begin
        sel_valid = input_valid[i];
        sel_last  = input_last[i];
        sel_data  = input_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Arbitration FSM next state and ready generation; grant locks until a last beat.
  always_comb begin
    state_next  = state;
    grant_next  = grant;
    rr_ptr_next = rr_ptr;
    input_ready = '0;
    case (state)
      ST_IDLE: begin
        if (pick_found) begin
          state_next = ST_GRANT;
          grant_next = pick_idx;
        end
      end
      ST_GRANT: begin
        for (int i = 0; i < NUM_REQ; i++) begin
          if (grant == SRC_WIDTH'(i)) begin
            input_ready[i] = stage_free;
          end
        end
        if (accept && sel_last) begin
          state_next  = ST_IDLE;
          rr_ptr_next = (grant == SRC_WIDTH'(NUM_REQ - 1)) ? '0 : grant + SRC_WIDTH'(1);
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Arbitration state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= ST_IDLE;
      grant  <= '0;
      rr_ptr <= '0;
    end else begin
      state  <= state_next;
      grant  <= grant_next;
      rr_ptr <= rr_ptr_next;
    end
  end

  // Single registered output stage; payload holds when not loading.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      output_valid <= 1'b0;
      output_data  <= '0;
      output_last  <= 1'b0;
      output_src   <= '0;
    end else if (accept) begin
      output_valid <= 1'b1;
      output_data  <= sel_data;
      output_last  <= sel_last;
      output_src   <= grant;
    end else if (output_ready) begin
      output_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_w0rm_stream_arbiter.sv
// tb/tb_w0rm_stream_arbiter.sv - self-checking bench for w0rm_stream_arbiter
module tb_w0rm_stream_arbiter;

  localparam int N  = 4;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    input_valid;
  logic [N-1:0]    input_ready;
  logic [N*DW-1:0] input_data;
  logic [N-1:0]    input_last;
  logic            output_valid;
  logic            output_ready;
  logic [DW-1:0]   output_data;
  logic            output_last;
  logic [1:0]      output_src;
  logic            busy;

  w0rm_stream_arbiter #(
    .NUM_REQ    (N),
    .DATA_WIDTH (DW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .input_valid  (input_valid),
    .input_ready  (input_ready),
    .input_data   (input_data),
    .input_last   (input_last),
    .output_valid (output_valid),
    .output_ready (output_ready),
    .output_data  (output_data),
    .output_last  (output_last),
    .output_src   (output_src),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Per-requester packet sources: {last, data}.
  logic [DW:0] srcq [N][$];
  bit          hold [N];

  typedef struct {
    int          src;
    bit          last;
    logic [DW-1:0] data;
    int          cyc;
  } beat_t;
  beat_t log_q[$];

  // Reference model state: who owns the channel, rotation pointer, output stage contents.
  bit            m_locked = 1'b0;
  int            m_owner  = 0;
  int            m_ptr    = 0;
  bit            m_ov     = 1'b0;
  logic [DW-1:0] m_od     = '0;
  bit            m_ol     = 1'b0;
  int            m_os     = 0;
  logic [N-1:0]  exp_ready;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s actual=no_event required=event_within_budget", name);
  endtask

  function automatic int rr_pick(input logic [N-1:0] v, input int ptr);
    for (int k = 0; k < N; k++) begin
      if (v[(ptr + k) % N]) return (ptr + k) % N;
    end
    return 0;
  endfunction

  always_comb begin
    exp_ready = '0;
    if (m_locked && (!m_ov || output_ready)) exp_ready[m_owner] = 1'b1;
  end

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_locked <= 1'b0;
      m_owner  <= 0;
      m_ptr    <= 0;
      m_ov     <= 1'b0;
      m_od     <= '0;
      m_ol     <= 1'b0;
      m_os     <= 0;
    end else if (!m_locked) begin
      if (input_valid != '0) begin
        m_locked <= 1'b1;
        m_owner  <= rr_pick(input_valid, m_ptr);
      end
      if (output_ready) m_ov <= 1'b0;
    end else if (input_valid[m_owner] && exp_ready[m_owner]) begin
      m_ov <= 1'b1;
      m_od <= input_data[m_owner*DW +: DW];
      m_ol <= input_last[m_owner];
      m_os <= m_owner;
      if (input_last[m_owner]) begin
        m_locked <= 1'b0;
        m_ptr    <= (m_owner + 1) % N;
      end
    end else if (output_ready) begin
      m_ov <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      check("cmp_output_valid", output_valid, m_ov);
      check("cmp_output_data", output_data, m_od);
      check("cmp_output_last", output_last, m_ol);
      check("cmp_output_src", output_src, m_os);
      check("cmp_busy", busy, m_locked);
      check("cmp_input_ready", input_ready, exp_ready);
      if (output_valid && output_ready)
        log_q.push_back('{src: int'(output_src), last: output_last, data: output_data, cyc: cyc});
    end
  end

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      if (srcq[i].size() > 0 && !hold[i]) begin
        input_valid[i]           = 1'b1;
        input_data[i*DW +: DW]   = srcq[i][0][DW-1:0];
        input_last[i]            = srcq[i][0][DW];
      end else begin
        input_valid[i]           = 1'b0;
        input_data[i*DW +: DW]   = '0;
        input_last[i]            = 1'b0;
      end
    end
  endtask

  task automatic tick();
    logic [N-1:0] take;
    @(negedge clk);
    take = input_valid & exp_ready;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (take[i]) void'(srcq[i].pop_front());
    end
    drive();
  endtask

  task automatic tick_until_size(input int r, input int sz, input string name);
    int n;
    n = 0;
    while (srcq[r].size() != sz && n < 20) begin
      tick();
      n++;
    end
    if (srcq[r].size() != sz) timeout(name);
  endtask

  task automatic reset_pulse();
    reset = 1'b1;
    for (int i = 0; i < N; i++) begin
      srcq[i].delete();
      hold[i] = 1'b0;
    end
    drive();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end

  initial begin
    int t0;
    int exp_src [8];
    reset        = 1'b1;
    input_valid  = '0;
    input_data   = '0;
    input_last   = '0;
    output_ready = 1'b1;
    for (int i = 0; i < N; i++) hold[i] = 1'b0;

    // Reset state
    @(posedge clk);
    #1;
    check("rst_output_valid", output_valid, 1'b0);
    check("rst_output_data", output_data, 32'h0);
    check("rst_output_src", output_src, 2'd0);
    check("rst_busy", busy, 1'b0);
    check("rst_input_ready", input_ready, 4'b0000);
    @(posedge clk);
    #1;
    reset = 1'b0;
    tick();
    tick();

    // Single 3-beat packet from requester 1
    log_q.delete();
    srcq[1].push_back({1'b0, 32'hA0});
    srcq[1].push_back({1'b0, 32'hA1});
    srcq[1].push_back({1'b1, 32'hA2});
    drive();
    t0 = cyc;
    repeat (8) tick();
    check("t2_count", log_q.size(), 3);
    for (int i = 0; i < 3; i++) begin
      if (i < log_q.size()) begin
        check("t2_data", log_q[i].data, 32'hA0 + i);
        check("t2_src", log_q[i].src, 1);
        check("t2_last", log_q[i].last, (i == 2));
        check("t2_cyc", log_q[i].cyc, t0 + 2 + i);
      end
    end

    // Round-robin fairness with 1-beat packets from all requesters
    reset_pulse();
    log_q.delete();
    for (int p = 0; p < 2; p++)
      for (int r = 0; r < N; r++)
        srcq[r].push_back({1'b1, 32'h300 + 32'(p * 16 + r)});
    drive();
    repeat (22) tick();
    exp_src = '{0, 1, 2, 3, 0, 1, 2, 3};
    check("t3_count", log_q.size(), 8);
    for (int i = 0; i < 8; i++) begin
      if (i < log_q.size()) begin
        check("t3_src", log_q[i].src, exp_src[i]);
        check("t3_data", log_q[i].data, 32'h300 + 32'((i / 4) * 16 + (i % 4)));
        if (i > 0) check("t3_spacing", log_q[i].cyc - log_q[i-1].cyc, 2);
      end
    end

    // Lock hold: requester 2 stalls mid-packet while 0 and 3 wait
    log_q.delete();
    srcq[2].push_back({1'b0, 32'h21});
    srcq[2].push_back({1'b1, 32'h22});
    drive();
    tick_until_size(2, 1, "t4_first_beat");
    hold[2] = 1'b1;
    srcq[0].push_back({1'b1, 32'h01});
    srcq[3].push_back({1'b1, 32'h31});
    drive();
    repeat (5) begin
      tick();
      check("t4_lock_ready", input_ready, 4'b0100);
    end
    hold[2] = 1'b0;
    drive();
    repeat (12) tick();
    check("t4_count", log_q.size(), 4);
    if (log_q.size() == 4) begin
      check("t4_b0", {log_q[0].src, log_q[0].data}, {32'd2, 32'h21});
      check("t4_b1", {log_q[1].src, log_q[1].data}, {32'd2, 32'h22});
      check("t4_b1_last", log_q[1].last, 1'b1);
      check("t4_b2", {log_q[2].src, log_q[2].data}, {32'd3, 32'h31});
      check("t4_b3", {log_q[3].src, log_q[3].data}, {32'd0, 32'h01});
    end

    // Backpressure with 0x55 pending
    log_q.delete();
    srcq[1].push_back({1'b0, 32'h55});
    srcq[1].push_back({1'b1, 32'h56});
    drive();
    tick_until_size(1, 1, "t5_first_beat");
    output_ready = 1'b0;
    repeat (4) begin
      tick();
      check("t5_hold_valid", output_valid, 1'b1);
      check("t5_hold_data", output_data, 32'h55);
      check("t5_hold_ready", input_ready, 4'b0000);
    end
    output_ready = 1'b1;
    repeat (6) tick();
    check("t5_count", log_q.size(), 2);
    if (log_q.size() == 2) begin
      check("t5_d0", log_q[0].data, 32'h55);
      check("t5_d1", log_q[1].data, 32'h56);
      check("t5_gap", log_q[1].cyc - log_q[0].cyc, 1);
    end

    // Reset mid-packet: asynchronous clear, pointer back to 0
    srcq[2].push_back({1'b0, 32'h61});
    srcq[2].push_back({1'b0, 32'h62});
    srcq[2].push_back({1'b0, 32'h63});
    srcq[2].push_back({1'b1, 32'h64});
    drive();
    tick_until_size(2, 2, "t6_two_beats");
    check("t6_pre_valid", output_valid, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    check("t6_async_valid", output_valid, 1'b0);
    check("t6_async_data", output_data, 32'h0);
    check("t6_async_last", output_last, 1'b0);
    check("t6_async_src", output_src, 2'd0);
    check("t6_async_busy", busy, 1'b0);
    check("t6_async_ready", input_ready, 4'b0000);
    for (int i = 0; i < N; i++) srcq[i].delete();
    drive();
    @(posedge clk);
    #1;
    reset = 1'b0;
    log_q.delete();
    srcq[3].push_back({1'b1, 32'h73});
    srcq[0].push_back({1'b1, 32'h70});
    drive();
    repeat (8) tick();
    check("t6_count", log_q.size(), 2);
    if (log_q.size() == 2) begin
      check("t6_first", {log_q[0].src, log_q[0].data}, {32'd0, 32'h70});
      check("t6_second", {log_q[1].src, log_q[1].data}, {32'd3, 32'h73});
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
